// File: rtl/user_edge_job_ctrl.sv
// user_edge_job_ctrl: sequences per-word OBI read requests to the edge accelerator, configured over an OBI slave
module user_edge_job_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH = 4,
  parameter logic [ID_WIDTH-1:0] JOB_ID = 4'h3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cfg_obi_req_i,
  input  logic [ADDR_WIDTH-1:0] cfg_obi_addr_i,
  input  logic [DATA_WIDTH-1:0] cfg_obi_wdata_i,
  input  logic                  cfg_obi_we_i,
  input  logic [ID_WIDTH-1:0]   cfg_obi_id_i,
  output logic                  cfg_obi_gnt_o,
  output logic                  cfg_obi_rvalid_o,
  output logic [DATA_WIDTH-1:0] cfg_obi_rdata_o,
  output logic [ID_WIDTH-1:0]   cfg_obi_rid_o,
  output logic                  cfg_obi_err_o,
  output logic                  mgr_obi_req_o,
  output logic [ADDR_WIDTH-1:0] mgr_obi_addr_o,
  output logic [DATA_WIDTH-1:0] mgr_obi_wdata_o,
  output logic                  mgr_obi_we_o,
  output logic [ID_WIDTH-1:0]   mgr_obi_id_o,
  input  logic                  mgr_obi_gnt_i,
  input  logic                  mgr_obi_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mgr_obi_rdata_i,
  input  logic [ID_WIDTH-1:0]   mgr_obi_rid_i,
  input  logic                  mgr_obi_err_i,
  output logic                  irq_o
);
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(DATA_WIDTH / 8);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_base, r_addr;
  logic [15:0]           r_count, r_progress;
  logic                  r_irq_en, r_busy, r_done, r_err, r_aborted, r_abort_pend, r_req, r_irq;
  logic                  r_rvalid, r_cfg_err;
  logic [DATA_WIDTH-1:0] r_rdata, w_rdata;
  logic [ID_WIDTH-1:0]   r_rid;
  logic [2:0]            w_off, w_w1c;
  logic                  w_wr, w_start, w_abort, w_lock, w_bad, w_hit, w_unused;
  assign w_off    = cfg_obi_addr_i[4:2];
  assign w_wr     = cfg_obi_req_i & cfg_obi_we_i;
  assign w_start  = w_wr && w_off == 3'd0 && cfg_obi_wdata_i[0];
  assign w_abort  = w_wr && w_off == 3'd0 && cfg_obi_wdata_i[2];
  assign w_w1c    = (w_wr && w_off == 3'd3) ? cfg_obi_wdata_i[3:1] : 3'b000;
  assign w_lock   = r_busy && (w_off == 3'd1 || w_off == 3'd2);
  assign w_bad    = w_off > 3'd4;
  assign w_hit    = mgr_obi_rvalid_i && mgr_obi_rid_i == JOB_ID;
  assign w_unused = ^{mgr_obi_rdata_i, cfg_obi_addr_i, cfg_obi_wdata_i};
  assign cfg_obi_gnt_o    = cfg_obi_req_i;
  assign cfg_obi_rvalid_o = r_rvalid;
  assign cfg_obi_rdata_o  = r_rdata;
  assign cfg_obi_rid_o    = r_rid;
  assign cfg_obi_err_o    = r_cfg_err;
  assign mgr_obi_req_o    = r_req;
  assign mgr_obi_addr_o   = r_addr;
  assign mgr_obi_wdata_o  = '0;
  assign mgr_obi_we_o     = 1'b0;
  assign mgr_obi_id_o     = JOB_ID;
  assign irq_o            = r_irq;
  // Register read mux, sampled on the grant cycle
  always_comb
    w_rdata = w_off == 3'd0 ? DATA_WIDTH'({r_irq_en, 1'b0}) :
              w_off == 3'd1 ? DATA_WIDTH'(r_base) :
              w_off == 3'd2 ? DATA_WIDTH'(r_count) :
              w_off == 3'd3 ? DATA_WIDTH'({r_aborted, r_err, r_done, r_busy}) :
              w_off == 3'd4 ? DATA_WIDTH'(r_progress) : '0;
  // Config slave: one-cycle response and programmable BASE/COUNT/IRQ_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rid     <= '0;
      r_cfg_err <= 1'b0;
      r_base    <= '0;
      r_count   <= '0;
      r_irq_en  <= 1'b0;
    end else begin
      r_rvalid  <= cfg_obi_req_i;
      r_cfg_err <= cfg_obi_req_i & (w_bad | (cfg_obi_we_i & w_lock));
      if (cfg_obi_req_i) begin
        r_rid   <= cfg_obi_id_i;
        r_rdata <= cfg_obi_we_i ? '0 : w_rdata;
      end
      if (w_wr && !w_lock) begin
        if (w_off == 3'd0) r_irq_en <= cfg_obi_wdata_i[1];
        if (w_off == 3'd1) r_base <= cfg_obi_wdata_i[ADDR_WIDTH-1:0] & ~ADDR_WIDTH'(3);
        if (w_off == 3'd2) r_count <= cfg_obi_wdata_i[15:0];
      end
    end
  end
  // Job FSM: one outstanding request at a time; FSM status updates override same-cycle W1C
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_progress   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_aborted    <= 1'b0;
      r_abort_pend <= 1'b0;
      r_req        <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      if (w_w1c[0]) r_done <= 1'b0;
      if (w_w1c[1]) r_err <= 1'b0;
      if (w_w1c[2]) r_aborted <= 1'b0;
      case (r_state)
        IDLE: if (w_start && !w_abort) begin
          r_progress   <= '0;
          r_err        <= 1'b0;
          r_aborted    <= 1'b0;
          r_abort_pend <= 1'b0;
          if (r_count != 16'd0) begin
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
            r_req   <= 1'b1;
            r_addr  <= r_base;
            r_state <= ISSUE;
          end else
            r_done <= 1'b1;
        end
        ISSUE: if (mgr_obi_gnt_i) begin
          r_req   <= 1'b0;
          r_state <= WAIT;
          if (w_abort) r_abort_pend <= 1'b1;
        end else if (w_abort) begin
          r_req     <= 1'b0;
          r_aborted <= 1'b1;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
        end
        WAIT: begin
          if (w_abort) r_abort_pend <= 1'b1;
          if (w_hit) begin
            r_progress <= r_progress + 16'd1;
            if (mgr_obi_err_i || r_progress + 16'd1 == r_count || r_abort_pend || w_abort) begin
              r_err     <= r_err | mgr_obi_err_i;
              r_aborted <= r_aborted | (!mgr_obi_err_i && r_progress + 16'd1 != r_count);
              r_done    <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= IDLE;
            end else begin
              r_req   <= 1'b1;
              r_addr  <= r_addr + STRIDE;
              r_state <= ISSUE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
      r_irq <= r_irq_en & r_done;
    end
  end
endmodule

// File: tb/tb_user_edge_job_ctrl.sv
// tb_user_edge_job_ctrl: directed checks of config access, job sequencing, error, abort and reset
module tb_user_edge_job_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cfg_req = 1'b0, cfg_we = 1'b0;
  logic [15:0] cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic [3:0]  cfg_id = '0;
  logic        cfg_gnt, cfg_rvalid, cfg_err;
  logic [31:0] cfg_rdata;
  logic [3:0]  cfg_rid;
  logic        mgr_req, mgr_we, irq;
  logic [15:0] mgr_addr;
  logic [31:0] mgr_wdata;
  logic [3:0]  mgr_id;
  logic        mgr_gnt = 1'b0, mgr_rvalid = 1'b0, mgr_err = 1'b0;
  logic [3:0]  mgr_rid = '0;
  int          n_checks = 0, n_pass = 0, nreq;
  logic [15:0] addrs [16];
  logic [31:0] rd;
  logic        er, seen;

  user_edge_job_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_obi_req_i(cfg_req), .cfg_obi_addr_i(cfg_addr), .cfg_obi_wdata_i(cfg_wdata),
    .cfg_obi_we_i(cfg_we), .cfg_obi_id_i(cfg_id), .cfg_obi_gnt_o(cfg_gnt),
    .cfg_obi_rvalid_o(cfg_rvalid), .cfg_obi_rdata_o(cfg_rdata), .cfg_obi_rid_o(cfg_rid),
    .cfg_obi_err_o(cfg_err),
    .mgr_obi_req_o(mgr_req), .mgr_obi_addr_o(mgr_addr), .mgr_obi_wdata_o(mgr_wdata),
    .mgr_obi_we_o(mgr_we), .mgr_obi_id_o(mgr_id), .mgr_obi_gnt_i(mgr_gnt),
    .mgr_obi_rvalid_i(mgr_rvalid), .mgr_obi_rdata_i(32'hDEAD_BEEF), .mgr_obi_rid_i(mgr_rid),
    .mgr_obi_err_i(mgr_err), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cfg(input logic we, input logic [15:0] a, input logic [31:0] wd,
                     output logic [31:0] r, output logic e);
    logic [3:0] id;
    id = cfg_id + 4'd1;
    @(negedge clk);
    cfg_req = 1'b1; cfg_we = we; cfg_addr = a; cfg_wdata = wd; cfg_id = id;
    #1 chk("cfg_gnt", {31'b0, cfg_gnt}, 1);
    @(negedge clk);
    cfg_req = 1'b0; cfg_we = 1'b0;
    chk("cfg_rvalid", {31'b0, cfg_rvalid}, 1);
    chk("cfg_rid", {28'b0, cfg_rid}, {28'b0, id});
    r = cfg_rdata; e = cfg_err;
  endtask

  // Accelerator stand-in: grants a pending request, completes 3 cycles after grant
  task automatic serve(input int cycles, input int err_at, input int abort_at, input bit rogue);
    int delay, ncomp;
    bit pending;
    nreq = 0; ncomp = 0; pending = 0; delay = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      mgr_gnt = 1'b0; mgr_rvalid = 1'b0; mgr_err = 1'b0; cfg_req = 1'b0; cfg_we = 1'b0;
      if (pending) begin
        delay--;
        if (delay == 2 && nreq == abort_at) begin
          cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = 16'h0; cfg_wdata = 32'h4;
        end
        if (delay == 2 && rogue && ncomp == 0) begin
          mgr_rvalid = 1'b1; mgr_rid = 4'h1;
        end
        if (delay == 0) begin
          ncomp++;
          mgr_rvalid = 1'b1; mgr_rid = 4'h3; mgr_err = (ncomp == err_at);
          pending = 0;
        end
      end else if (mgr_req) begin
        mgr_gnt = 1'b1;
        if (nreq < 16) addrs[nreq] = mgr_addr;
        nreq++; pending = 1; delay = 3;
      end
    end
    @(negedge clk);
    mgr_gnt = 1'b0; mgr_rvalid = 1'b0; mgr_err = 1'b0; cfg_req = 1'b0; cfg_we = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_mgr_req", {31'b0, mgr_req}, 0);
    chk("rst_mgr_id", {28'b0, mgr_id}, 3);
    chk("rst_irq", {31'b0, irq}, 0);
    chk("rst_cfg_rvalid", {31'b0, cfg_rvalid}, 0);
    chk("rst_mgr_we_wdata", {mgr_wdata[30:0], mgr_we}, 0);
    @(negedge clk); rst_n = 1'b1;

    cfg(1, 16'h4, 32'h0100, rd, er);
    cfg(1, 16'h8, 32'd3, rd, er);
    cfg(1, 16'h0, 32'h3, rd, er);
    serve(40, 0, 0, 1);
    chk("t1_nreq", nreq, 3);
    chk("t1_addr0", addrs[0], 16'h0100);
    chk("t1_addr1", addrs[1], 16'h0104);
    chk("t1_addr2", addrs[2], 16'h0108);
    cfg(0, 16'hC, 0, rd, er); chk("t1_status", rd, 32'h2);
    cfg(0, 16'h10, 0, rd, er); chk("t1_progress", rd, 3);
    cfg(0, 16'h0, 0, rd, er); chk("t1_ctrl_rd", rd, 32'h2);
    chk("t1_irq", {31'b0, irq}, 1);
    cfg(1, 16'hC, 32'h2, rd, er);
    @(negedge clk);
    chk("t1_irq_clr", {31'b0, irq}, 0);
    cfg(0, 16'hC, 0, rd, er); chk("t1_status_clr", rd, 0);

    seen = 1'b0;
    cfg(1, 16'h8, 32'd0, rd, er);
    cfg(1, 16'h0, 32'h1, rd, er);
    seen |= mgr_req;
    for (int i = 0; i < 4; i++) begin @(negedge clk); seen |= mgr_req; end
    chk("t2_no_req", {31'b0, seen}, 0);
    cfg(0, 16'hC, 0, rd, er); chk("t2_status", rd, 32'h2);
    cfg(0, 16'h10, 0, rd, er); chk("t2_progress", rd, 0);
    chk("t2_irq_off", {31'b0, irq}, 0);

    cfg(1, 16'h4, 32'hFFFF, rd, er);
    cfg(0, 16'h4, 0, rd, er); chk("t3_base_mask", rd, 32'hFFFC);
    cfg(1, 16'h8, 32'd2, rd, er);
    cfg(1, 16'h0, 32'h1, rd, er);
    serve(30, 0, 0, 0);
    chk("t3_nreq", nreq, 2);
    chk("t3_addr0", addrs[0], 16'hFFFC);
    chk("t3_addr1", addrs[1], 16'h0000);

    cfg(1, 16'h4, 32'h0200, rd, er);
    cfg(1, 16'h8, 32'd4, rd, er);
    cfg(1, 16'h0, 32'h1, rd, er);
    serve(40, 2, 0, 0);
    chk("t4_nreq", nreq, 2);
    cfg(0, 16'hC, 0, rd, er); chk("t4_status", rd, 32'h6);
    cfg(0, 16'h10, 0, rd, er); chk("t4_progress", rd, 2);

    cfg(1, 16'h8, 32'd8, rd, er);
    cfg(1, 16'h0, 32'h1, rd, er);
    serve(60, 0, 3, 0);
    chk("t5_nreq", nreq, 3);
    chk("t5_addr2", addrs[2], 16'h0208);
    cfg(0, 16'h10, 0, rd, er); chk("t5_progress", rd, 3);
    cfg(0, 16'hC, 0, rd, er); chk("t5_status", rd, 32'hA);

    cfg(1, 16'h8, 32'd2, rd, er);
    cfg(1, 16'h0, 32'h1, rd, er);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      seen |= (mgr_req !== 1'b1) || (mgr_addr !== 16'h0200);
    end
    chk("t6_req_held", {31'b0, seen}, 0);
    cfg(1, 16'h8, 32'd5, rd, er); chk("t6_busy_wr_err", {31'b0, er}, 1);
    cfg(0, 16'h8, 0, rd, er); chk("t6_count_kept", rd, 2);
    chk("t6_count_rd_err", {31'b0, er}, 0);
    cfg(1, 16'h0, 32'h4, rd, er);
    chk("t6_req_dropped", {31'b0, mgr_req}, 0);
    cfg(0, 16'hC, 0, rd, er); chk("t6_status", rd, 32'hA);
    cfg(0, 16'h10, 0, rd, er); chk("t6_progress", rd, 0);

    cfg(1, 16'hC, 32'hE, rd, er);
    seen = 1'b0;
    cfg(1, 16'h0, 32'h5, rd, er);
    for (int i = 0; i < 3; i++) begin @(negedge clk); seen |= mgr_req; end
    chk("t7_no_req", {31'b0, seen}, 0);
    cfg(0, 16'hC, 0, rd, er); chk("t7_status", rd, 0);
    cfg(0, 16'h18, 0, rd, er);
    chk("t7_bad_err", {31'b0, er}, 1);
    chk("t7_bad_rdata", rd, 0);

    cfg(1, 16'h0, 32'h1, rd, er);
    chk("t8_req_up", {31'b0, mgr_req}, 1);
    rst_n = 1'b0;
    #1 chk("t8_req_rst", {31'b0, mgr_req}, 0);
    @(negedge clk); rst_n = 1'b1;
    cfg(0, 16'hC, 0, rd, er); chk("t8_status", rd, 0);
    cfg(0, 16'h8, 0, rd, er); chk("t8_count", rd, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
